// File: rtl/debug_pkg.sv
// Shared constants for the MIPS debug run/step controller: state encoding,
// command bytes and default widths.
package debug_pkg;

    localparam int unsigned PC_W_DEF  = 32;
    localparam int unsigned CMD_W     = 8;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned BP_W      = 32;
    localparam int unsigned BP_BYTES  = 4;
    localparam int unsigned BP_CNT_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP      = 3'd3,
        ST_DUMP_REQ  = 3'd4,
        ST_DUMP_WAIT = 3'd5,
        ST_BP_RX     = 3'd6
    } state_e;

    localparam logic [CMD_W-1:0] CMD_LOAD  = 8'h4C;
    localparam logic [CMD_W-1:0] CMD_RUN   = 8'h52;
    localparam logic [CMD_W-1:0] CMD_STEP  = 8'h53;
    localparam logic [CMD_W-1:0] CMD_DUMP  = 8'h44;
    localparam logic [CMD_W-1:0] CMD_HALT  = 8'h48;
    localparam logic [CMD_W-1:0] CMD_BREAK = 8'h42;

endpackage

// File: rtl/debug_run_ctrl_if.sv
// Signal bundle between the run/step controller and its neighbours
// (UART RX command bytes, loader, core enable, dump engine).
// master: the controller; slave: the surrounding debug subsystem.
interface debug_run_ctrl_if #(
    parameter int unsigned PC_W = 32
);
    logic            cmd_valid;
    logic [7:0]      cmd_data;
    logic            load_done;
    logic            halt_seen;
    logic [PC_W-1:0] pc;
    logic            dump_done;
    logic            cpu_en;
    logic            pc_rst;
    logic            load_en;
    logic            dump_start;
    logic            ended;
    logic            cmd_err;
    logic [2:0]      state_o;

    modport master (
        input  cmd_valid, cmd_data, load_done, halt_seen, pc, dump_done,
        output cpu_en, pc_rst, load_en, dump_start, ended, cmd_err, state_o
    );

    modport slave (
        output cmd_valid, cmd_data, load_done, halt_seen, pc, dump_done,
        input  cpu_en, pc_rst, load_en, dump_start, ended, cmd_err, state_o
    );
endinterface

// File: rtl/step_counter.sv
// Loadable down-counter for single-step length; flags when the count is one.
module step_counter #(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic is_one_o
);
    localparam int unsigned CNT_W = $clog2(STEP_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             one_q;

    // Next count: load wins over decrement, saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(STEP_CYCLES);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register; the one-flag is registered from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            one_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            one_q <= (cnt_d == CNT_W'(1));
        end
    end

    assign is_one_o = one_q;
endmodule

// File: rtl/debug_run_ctrl.sv
// Run/step controller for the MIPS debug subsystem: decodes UART command
// bytes and sequences load, run, single-step and state dump.
// Optional PC breakpoint capture/compare enabled by DEBUG_BREAKPOINT_EN.
module debug_run_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned PC_W        = PC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    debug_run_ctrl_if.master dbg
);
    state_e state_q, state_d;
    logic   pc_rst_q, pc_rst_d;
    logic   cmd_err_q, cmd_err_d;
    logic   ended_q, ended_d;
    logic   cnt_load_c, cnt_dec_c, cnt_one;

`ifdef DEBUG_BREAKPOINT_EN
    logic [BP_W-1:0]     bp_addr_q, bp_addr_d;
    logic                bp_valid_q, bp_valid_d;
    logic [BP_CNT_W-1:0] bp_cnt_q, bp_cnt_d;
    logic                bp_skip_q, bp_skip_d;
    logic                bp_match_c;

    assign bp_match_c = bp_valid_q && (dbg.pc == PC_W'(bp_addr_q));
`else
    logic [PC_W-1:0] unused_pc;
    assign unused_pc = dbg.pc;
`endif

    step_counter #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .load_i   (cnt_load_c),
        .dec_i    (cnt_dec_c),
        .is_one_o (cnt_one)
    );

    // Next-state and side-effect decode.
    always_comb begin
        state_d    = state_q;
        pc_rst_d   = 1'b0;
        cmd_err_d  = 1'b0;
        ended_d    = ended_q;
        cnt_load_c = 1'b0;
        cnt_dec_c  = 1'b0;
`ifdef DEBUG_BREAKPOINT_EN
        bp_addr_d  = bp_addr_q;
        bp_valid_d = bp_valid_q;
        bp_cnt_d   = bp_cnt_q;
        bp_skip_d  = bp_skip_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dbg.cmd_valid) begin
                    case (dbg.cmd_data)
                        CMD_LOAD: begin
                            state_d  = ST_LOAD;
                            pc_rst_d = 1'b1;
                            ended_d  = 1'b0;
                        end
                        CMD_RUN: begin
                            if (ended_q) begin
                                cmd_err_d = 1'b1;
                            end else begin
                                state_d = ST_RUN;
`ifdef DEBUG_BREAKPOINT_EN
                                // Resuming from the breakpoint PC must not re-hit it.
                                bp_skip_d = bp_match_c;
`endif
                            end
                        end
                        CMD_STEP: begin
                            if (ended_q) begin
                                cmd_err_d = 1'b1;
                            end else begin
                                state_d    = ST_STEP;
                                cnt_load_c = 1'b1;
                            end
                        end
                        CMD_DUMP: state_d = ST_DUMP_REQ;
`ifdef DEBUG_BREAKPOINT_EN
                        CMD_BREAK: begin
                            state_d    = ST_BP_RX;
                            bp_valid_d = 1'b0;
                            bp_cnt_d   = '0;
                        end
`endif
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            ST_LOAD: begin
                if (dbg.load_done) state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (dbg.halt_seen) begin
                    ended_d = 1'b1;
                    state_d = ST_DUMP_REQ;
                end else if (dbg.cmd_valid && (dbg.cmd_data == CMD_HALT)) begin
                    state_d = ST_DUMP_REQ;
                end
`ifdef DEBUG_BREAKPOINT_EN
                else if (bp_match_c && !bp_skip_q) begin
                    state_d = ST_DUMP_REQ;
                end
                bp_skip_d = 1'b0;
`endif
            end
            ST_STEP: begin
                cnt_dec_c = 1'b1;
                if (dbg.halt_seen) begin
                    ended_d = 1'b1;
                    state_d = ST_DUMP_REQ;
                end else if (cnt_one) begin
                    state_d = ST_DUMP_REQ;
                end
            end
            ST_DUMP_REQ: state_d = ST_DUMP_WAIT;
            ST_DUMP_WAIT: begin
                if (dbg.dump_done) state_d = ST_IDLE;
            end
`ifdef DEBUG_BREAKPOINT_EN
            ST_BP_RX: begin
                if (dbg.cmd_valid) begin
                    bp_addr_d = {bp_addr_q[BP_W-CMD_W-1:0], dbg.cmd_data};
                    if (bp_cnt_q == BP_CNT_W'(BP_BYTES - 1)) begin
                        bp_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        bp_cnt_d = bp_cnt_q + BP_CNT_W'(1);
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_rst_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            ended_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_rst_q  <= pc_rst_d;
            cmd_err_q <= cmd_err_d;
            ended_q   <= ended_d;
        end
    end

`ifdef DEBUG_BREAKPOINT_EN
    // Breakpoint address capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_addr_q  <= '0;
            bp_valid_q <= 1'b0;
            bp_cnt_q   <= '0;
            bp_skip_q  <= 1'b0;
        end else begin
            bp_addr_q  <= bp_addr_d;
            bp_valid_q <= bp_valid_d;
            bp_cnt_q   <= bp_cnt_d;
            bp_skip_q  <= bp_skip_d;
        end
    end
`endif

    assign dbg.cpu_en     = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign dbg.load_en    = (state_q == ST_LOAD);
    assign dbg.dump_start = (state_q == ST_DUMP_REQ);
    assign dbg.pc_rst     = pc_rst_q;
    assign dbg.cmd_err    = cmd_err_q;
    assign dbg.ended      = ended_q;
    assign dbg.state_o    = state_q;
endmodule

// File: tb/tb_debug_run_ctrl.sv
// Bench for debug_run_ctrl (STEP_CYCLES=3). Breakpoint scenario is built
// only when DEBUG_BREAKPOINT_EN is defined.
module tb_debug_run_ctrl;
    localparam int unsigned K = 3;

    logic clk;
    logic rst;

    debug_run_ctrl_if #(.PC_W(32)) dbg ();

    debug_run_ctrl #(
        .STEP_CYCLES (K),
        .PC_W        (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dbg (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       cpu_en;
        logic       pc_rst;
        logic       load_en;
        logic       dump_start;
        logic       ended;
        logic       cmd_err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   en_cnt = 0;
    int   ds_cnt = 0;
    logic m_ended = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    // Expected outputs for a given spec-level activity.
    function automatic exp_t ex(input int st);
        exp_t e;
        e.st         = 3'(st);
        e.cpu_en     = (st == 2) || (st == 3);
        e.load_en    = (st == 1);
        e.dump_start = (st == 4);
        e.ended      = m_ended;
        e.pc_rst     = 1'b0;
        e.cmd_err    = 1'b0;
        return e;
    endfunction

    // Per-cycle checker against the queued expectations.
    always @(posedge clk) begin
        #1;
        if (dbg.cpu_en === 1'b1) en_cnt++;
        if (dbg.dump_start === 1'b1) ds_cnt++;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state_o",    32'(dbg.state_o),    32'(e.st));
            chk("cpu_en",     32'(dbg.cpu_en),     32'(e.cpu_en));
            chk("pc_rst",     32'(dbg.pc_rst),     32'(e.pc_rst));
            chk("load_en",    32'(dbg.load_en),    32'(e.load_en));
            chk("dump_start", 32'(dbg.dump_start), 32'(e.dump_start));
            chk("ended",      32'(dbg.ended),      32'(e.ended));
            chk("cmd_err",    32'(dbg.cmd_err),    32'(e.cmd_err));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic drive(input logic cv, input logic [7:0] d, input logic ld,
                         input logic hs, input logic dd, input logic [31:0] p,
                         input exp_t e);
        @(negedge clk);
        dbg.cmd_valid = cv;
        dbg.cmd_data  = d;
        dbg.load_done = ld;
        dbg.halt_seen = hs;
        dbg.dump_done = dd;
        dbg.pc        = p;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        dbg.cmd_valid = 1'b0;
        dbg.cmd_data  = 8'h00;
        dbg.load_done = 1'b0;
        dbg.halt_seen = 1'b0;
        dbg.dump_done = 1'b0;
    endtask

    task automatic idle_n(input int st, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, dbg.pc, ex(st));
    endtask

    // Command issued from IDLE: expected result follows the command table.
    task automatic idle_cmd(input logic [7:0] c);
        exp_t e;
        int   nst;
        logic err;
        nst = 0;
        err = 1'b0;
        case (c)
            8'h4C: begin nst = 1; m_ended = 1'b0; end
            8'h52: if (m_ended) err = 1'b1; else nst = 2;
            8'h53: if (m_ended) err = 1'b1; else nst = 3;
            8'h44: nst = 4;
`ifdef DEBUG_BREAKPOINT_EN
            8'h42: nst = 6;
`endif
            default: err = 1'b1;
        endcase
        e = ex(nst);
        e.pc_rst  = (c == 8'h4C);
        e.cmd_err = err;
        drive(1'b1, c, 1'b0, 1'b0, 1'b0, dbg.pc, e);
    endtask

    // From DUMP_REQ: wait some cycles, then dump_done returns to IDLE.
    task automatic finish_dump(input int waits);
        idle_n(5, waits);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, dbg.pc, ex(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0;
        int ds0;
        rst = 1'b1;
        dbg.cmd_valid = 1'b0;
        dbg.cmd_data  = 8'h00;
        dbg.load_done = 1'b0;
        dbg.halt_seen = 1'b0;
        dbg.dump_done = 1'b0;
        dbg.pc        = 32'h0;
        #1;
        chk("rst_state",      32'(dbg.state_o),    32'd0);
        chk("rst_cpu_en",     32'(dbg.cpu_en),     32'd0);
        chk("rst_load_en",    32'(dbg.load_en),    32'd0);
        chk("rst_dump_start", 32'(dbg.dump_start), 32'd0);
        chk("rst_ended",      32'(dbg.ended),      32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_n(0, 2);

        // Load: pc_rst one cycle, load_en until load_done.
        idle_cmd(8'h4C);
        idle_n(1, 3);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, ex(0));
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, ex(0));

        // Step of K cycles, then one dump_start pulse.
        en0 = en_cnt;
        ds0 = ds_cnt;
        idle_cmd(8'h53);
        idle_n(3, K - 1);
        idle_n(4, 1);
        idle_n(5, 1);
        drive(1'b1, 8'h53, 1'b0, 1'b0, 1'b0, 32'h0, ex(5));
        finish_dump(1);
        chk("step_cpu_en_cycles", 32'(en_cnt - en0), 32'd3);
        chk("step_dump_pulses",   32'(ds_cnt - ds0), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0, ex(0));

        // Run; non-halt command ignored; halt and 'H' together -> ended.
        idle_cmd(8'h52);
        idle_n(2, 2);
        drive(1'b1, 8'h53, 1'b0, 1'b0, 1'b0, 32'h0, ex(2));
        m_ended = 1'b1;
        drive(1'b1, 8'h48, 1'b0, 1'b1, 1'b0, 32'h0, ex(4));
        finish_dump(2);
        chk("ended_after_halt", 32'(dbg.ended), 32'd1);

        // Run/step refused once ended; other bad bytes.
        en0 = en_cnt;
        idle_cmd(8'h52);
        idle_n(0, 1);
        idle_cmd(8'h53);
        idle_cmd(8'h5A);
        idle_n(0, 1);
        chk("no_cpu_en_when_ended", 32'(en_cnt - en0), 32'd0);

        // Plain dump from IDLE keeps ended.
        idle_cmd(8'h44);
        finish_dump(1);

        // Reload clears ended; halt inside a step stops it early.
        idle_cmd(8'h4C);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, ex(0));
        idle_cmd(8'h53);
        m_ended = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, ex(4));
        finish_dump(1);
        idle_cmd(8'h4C);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, ex(0));

`ifdef DEBUG_BREAKPOINT_EN
        // Breakpoint at 0x1C, bytes MSB first with a gap cycle.
        idle_cmd(8'h42);
        idle_n(6, 1);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, ex(6));
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, ex(6));
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, ex(6));
        drive(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 32'h0, ex(0));
        idle_cmd(8'h52);
        for (int a = 4; a < 32'h1C; a += 4)
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'(a), ex(2));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h1C, ex(4));
        finish_dump(1);
        chk("bp_stop_not_ended", 32'(dbg.ended), 32'd0);
        // Resume at the breakpoint PC: one free cycle before it re-arms.
        idle_cmd(8'h52);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h1C, ex(2));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h1C, ex(4));
        finish_dump(1);
        dbg.pc = 32'h0;
`else
        // Without breakpoint support 'B' is an unknown command.
        idle_cmd(8'h42);
        idle_n(0, 1);
`endif

        // Asynchronous reset while running.
        idle_cmd(8'h52);
        idle_n(2, 1);
        @(posedge clk);
        #3;
        chk("cpu_en_before_rst", 32'(dbg.cpu_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_cpu_en", 32'(dbg.cpu_en),  32'd0);
        chk("async_rst_state",  32'(dbg.state_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_ended = 1'b0;
        idle_n(0, 2);

        repeat (3) @(negedge clk);
        chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
